interrupt_controller: RTL
=========================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of interrupt channels; legal range 1..16.
REQ-002 Parameter LEVEL_DEFAULT, default 0, SHALL be the MODE register value at reset (bit=1 means level-sensitive).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 address  input  4  SHALL be the register select from the device map.
REQ-006 enable  input  1  SHALL be the device select.
REQ-007 mode  input  1  SHALL select the access type: 1=write, 0=read.
REQ-008 data_in  input  8  SHALL be the write data.
REQ-009 data_out  output  8  SHALL be the read data, tri-stated when not selected.
REQ-010 irq_in  input  WIDTH  SHALL be the raw interrupt request per channel.
REQ-011 processing  input  1  SHALL be the FSM service flag, high while the handler runs.
REQ-012 irq_out  output  WIDTH  SHALL be a one-hot request to the FSM.
REQ-013 irq_vector  output  4  SHALL be the index of the asserted channel.

Function
REQ-014 The register map SHALL be:
- 0/1 PEND lo/hi: read pending; write 1 clears.
- 2/3 MASK lo/hi: 1=enabled.
- 4/5 MODE lo/hi: 1=level.
- 6 CTRL: bit0 global enable.
- 7 STATUS: [3:0] vector, [5:4] state encoding (read-only).
- 8-15: read 0, writes ignored.
REQ-015 Bits at or above WIDTH SHALL read 0 and ignore writes.
REQ-016 data_out SHALL be driven combinationally only when enable=1 and mode=0, and SHALL be high-Z otherwise.
REQ-017 Writes SHALL take effect at the clock edge where enable=1 and mode=1.
REQ-018 Each channel SHALL register irq_in once (prev) and then set pending as follows:
- edge mode: on irq_in=1 and prev=0;
- level mode: on every cycle irq_in=1.
REQ-019 The FSM SHALL have states IDLE(00), ASSERT(01), SERVICE(10).
REQ-020 IDLE -> ASSERT SHALL occur when CTRL.bit0=1 and (PEND & MASK)!=0. On that transition the lowest-index qualifying channel is latched as vector.
REQ-021 In ASSERT, irq_out SHALL be one-hot at vector and irq_vector SHALL equal vector. Otherwise irq_out=0 and irq_vector holds its last value.
REQ-022 ASSERT -> SERVICE SHALL occur on processing=1; the latched channel's pending bit clears on that edge.
REQ-023 SERVICE -> IDLE SHALL occur on processing=0; irq_out stays 0 in SERVICE.
REQ-024 Latency: an irq_in rising edge sampled at edge k SHALL set pending at edge k; irq_out asserts after edge k+1 (2 cycles from the input).
REQ-025 If a pending set and a clear (software or service) hit the same bit in the same cycle, the set SHALL win.
REQ-026 The latched channel SHALL remain asserted in ASSERT even if its mask, CTRL, or pending bit is cleared by software.
REQ-027 Requests arriving during ASSERT/SERVICE SHALL accumulate in PEND and be arbitrated on return to IDLE.
REQ-028 Level-mode channels still high after service SHALL re-pend on the next cycle.

Reset
REQ-029 While rst_n=0 at a clock edge:
- PEND=0, MASK=0, MODE=LEVEL_DEFAULT, CTRL=0;
- prev=0, state=IDLE, vector=0;
- irq_out=0, irq_vector=0.
REQ-030 Reset mid-ASSERT or mid-SERVICE SHALL abort to IDLE with irq_out=0 on the following cycle.

Verification
REQ-031 Set MASK=0xFF and CTRL=1, pulse irq_in[3] for 1 cycle -> PEND=0x08 and irq_out=0x08, irq_vector=3 two cycles later; raise processing -> PEND=0x00, STATUS[5:4]=10.
REQ-032 Raise irq_in[5] and irq_in[2] in the same cycle -> channel 2 is served first; after processing falls, channel 5 is asserted.
REQ-033 Set MASK=0xFB and pulse irq_in[2] -> PEND=0x04 and irq_out=0; then write MASK=0xFF -> irq_out=0x04.
REQ-034 Set MODE lo=0x01 and hold irq_in[0] high through service -> PEND bit0 re-sets one cycle after processing=1, and channel 0 re-asserts after SERVICE->IDLE.
REQ-035 Write PEND lo=0x02 in the same cycle as a rising edge on irq_in[1] -> PEND bit1 remains 1.
REQ-036 Drive rst_n=0 during ASSERT with irq_out=0x10 -> irq_out=0, STATUS=0x00, MASK=0 after the edge; data_out is high-Z whenever enable=0.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller: register-mapped interrupt controller with edge/level channels and one-hot FSM request
// Ports:
//    clk, rst_n        - clock, synchronous active-low reset
//    address, enable,  - register select, device select,
//    mode, data_in     - access type (1=write, 0=read), write data
//    data_out          - read data, high-Z unless a read is selected
//    irq_in            - raw request per channel
//    processing        - handler-running flag from the servicing FSM
//    irq_out           - one-hot request to the servicing FSM
//    irq_vector        - index of the latched channel
module interrupt_controller #(
   parameter int          WIDTH         = 8,
   parameter logic [15:0] LEVEL_DEFAULT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       address,
   input  logic             enable,
   input  logic             mode,
   input  logic [7:0]       data_in,
   output logic [7:0]       data_out,
   input  logic [WIDTH-1:0] irq_in,
   input  logic             processing,
   output logic [WIDTH-1:0] irq_out,
   output logic [3:0]       irq_vector
);
   typedef enum logic [1:0] {IDLE = 2'b00, ASSERT = 2'b01, SERVICE = 2'b10} state_t;
   state_t           state;
   logic [WIDTH-1:0] pend, msk, lvl, prev, irq_r, set, clr, be, wd, qual, first;
   logic             ctrl, wr;
   logic [3:0]       vec, idx;
   logic [15:0]      rsel;
   logic [7:0]       rdata;
   assign wr         = enable & mode;
   assign qual       = pend & msk;
   assign set        = irq_in & (lvl | ~prev);
   // service clear uses the latched one-hot, so software changes to PEND/MASK cannot redirect it
   assign clr        = ((wr && address[3:1] == 3'd0) ? (wd & be) : '0) |
                       ((state == ASSERT && processing) ? irq_r : '0);
   assign irq_out    = irq_r;
   assign irq_vector = vec;
   // be selects the channels covered by the lo/hi byte being accessed; wd spreads data_in onto them
   always_comb begin
      be    = '0;
      wd    = '0;
      idx   = '0;
      first = '0;
      for (int i = 0; i < WIDTH; i++) begin
         be[i] = address[0] == (i >= 8);
         wd[i] = data_in[i % 8];
      end
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (qual[i]) begin
            idx      = 4'(i);
            first    = '0;
            first[i] = 1'b1;
         end
      end
   end
   always_comb begin
      rsel  = address[3:1] == 3'd0 ? 16'(pend) :
              address[3:1] == 3'd1 ? 16'(msk)  :
              address[3:1] == 3'd2 ? 16'(lvl)  : '0;
      rdata = address == 4'd6 ? {7'b0, ctrl} :
              address == 4'd7 ? {2'b0, state, vec} :
              address[0]      ? rsel[15:8] : rsel[7:0];
   end
   assign data_out = (enable && !mode) ? rdata : 8'bz;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend  <= '0;
         msk   <= '0;
         lvl   <= LEVEL_DEFAULT[WIDTH-1:0];
         ctrl  <= 1'b0;
         prev  <= '0;
         state <= IDLE;
         vec   <= '0;
         irq_r <= '0;
      end else begin
         prev <= irq_in;
         // set is applied after clear so a simultaneous set wins
         pend <= (pend & ~clr) | set;
         if (wr && address[3:1] == 3'd1) msk <= (msk & ~be) | (wd & be);
         if (wr && address[3:1] == 3'd2) lvl <= (lvl & ~be) | (wd & be);
         if (wr && address == 4'd6) ctrl <= data_in[0];
         case (state)
            IDLE: if (ctrl && |qual) begin
               state <= ASSERT;
               vec   <= idx;
               irq_r <= first;
            end
            ASSERT: if (processing) begin
               state <= SERVICE;
               irq_r <= '0;
            end
            SERVICE: if (!processing) state <= IDLE;
            default: begin
               state <= IDLE;
               irq_r <= '0;
            end
         endcase
      end
   end
endmodule
